// File: rtl/ysyx_lsu_sram_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_lsu_sram_pkg
//   Shared ysyx definitions: ALU operation codes, the default memory map of
//   the on-chip data SRAM, and the LSU SRAM controller state encoding.
//   No ports; imported with `import ysyx_lsu_sram_pkg::*;`.
// ---------------------------------------------------------------------------
package ysyx_lsu_sram_pkg;

   // Default memory map of the data SRAM.
   localparam logic [31:0] YSYX_MEM_BASE  = 32'h8000_0000;
   localparam int          YSYX_MEM_WORDS = 1024;

   // ALU operation codes used by the execute stage.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   // LSU SRAM controller states.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      RD_RESP = 3'd2,
      WR_WAIT = 3'd3,
      WR_RESP = 3'd4
   } lsu_state_e;

endpackage

// File: rtl/ysyx_sram_1rw.sv
// ---------------------------------------------------------------------------
// ysyx_sram_1rw
//   Single-port SRAM with per-byte write enables, synchronous write and a
//   registered read port. Contents are never reset; only the read register is.
//
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset (read register only)
//   en       in   port access this cycle
//   we       in   1 = write, 0 = read
//   be       in   byte write enables
//   idx      in   word index
//   wdata    in   write data (already lane-aligned)
//   rd_zero  in   on a read, load zero instead of the array word
//   rdata    out  registered read data; holds between reads
// ---------------------------------------------------------------------------
module ysyx_sram_1rw #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  we,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [IDX_W-1:0]      idx,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  rd_zero,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (en && !we) begin
         rdata <= rd_zero ? '0 : mem[idx];
      end
   end

endmodule

// File: rtl/ysyx_lsu_sram.sv
// ---------------------------------------------------------------------------
// ysyx_lsu_sram
//   Fixed-latency SRAM slave for the LSU. One transaction at a time; a load
//   wins over a simultaneous store. Address decode, latency counting and the
//   store lane shift live here; storage is ysyx_sram_1rw.
//
//   Handshake: the initiator raises arvalid (or awvalid+wvalid) and holds it
//   until the one-cycle rvalid (or wready) pulse. A request is accepted on a
//   rising edge while the FSM is IDLE; everything needed is latched there, so
//   the request inputs are ignored until the FSM returns to IDLE.
//
//   clk, rst_n         clock / synchronous active-low reset
//   araddr, arvalid    load byte address and request
//   rstrb              load byte mask (informational)
//   rdata, rvalid      aligned load word and its one-cycle valid pulse
//   awaddr, awvalid    store byte address and address valid
//   wdata, wstrb       LSB-justified store data and byte mask
//   wvalid, wready     store data valid and one-cycle completion pulse
//   dbg_state          current FSM state
// ---------------------------------------------------------------------------
module ysyx_lsu_sram
   import ysyx_lsu_sram_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                MEM_WORDS = YSYX_MEM_WORDS,
   parameter logic [ADDR_W-1:0] BASE      = ADDR_W'(YSYX_MEM_BASE),
   parameter int                RD_LAT    = 2,
   parameter int                WR_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   input  logic [7:0]        rstrb,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   input  logic [DATA_W-1:0] wdata,
   input  logic [7:0]        wstrb,
   input  logic              wvalid,
   output logic              wready,
   output lsu_state_e        dbg_state
);

   localparam int NB      = DATA_W / 8;
   localparam int IDX_W   = $clog2(MEM_WORDS);
   localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   lsu_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q;
   logic              oor_q;
   logic [NB-1:0]     be_q;
   logic [DATA_W-1:0] wdata_q;
   logic              latch_rd, latch_wr;

   // Address decode: byte offset from BASE, word index, out-of-range flag.
   logic [ADDR_W-1:0] ar_off, aw_off;
   logic [IDX_W-1:0]  ar_idx, aw_idx;
   logic              ar_oor, aw_oor;
   logic [NB-1:0]     aw_be;
   logic [DATA_W-1:0] aw_wdata;

   assign ar_off = araddr - BASE;
   assign aw_off = awaddr - BASE;
   assign ar_oor = (araddr < BASE) || ((ar_off >> 2) >= ADDR_W'(MEM_WORDS));
   assign aw_oor = (awaddr < BASE) || ((aw_off >> 2) >= ADDR_W'(MEM_WORDS));
   assign ar_idx = ar_off[IDX_W+1:2];
   assign aw_idx = aw_off[IDX_W+1:2];

   // Store data arrives LSB-justified; move it to its byte lane. Strobe bits
   // pushed past the top lane fall off, so a misaligned store never wraps.
   assign aw_be    = NB'(wstrb << aw_off[1:0]);
   assign aw_wdata = wdata << {aw_off[1:0], 3'b000};

   // The load mask carries no information the SRAM needs: it returns whole words.
   logic unused_rstrb;
   assign unused_rstrb = ^rstrb;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         oor_q   <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch_rd) begin
            idx_q <= ar_idx;
            oor_q <= ar_oor;
         end else if (latch_wr) begin
            idx_q   <= aw_idx;
            oor_q   <= aw_oor;
            be_q    <= aw_be;
            wdata_q <= aw_wdata;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      latch_rd = 1'b0;
      latch_wr = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arvalid) begin
               latch_rd = 1'b1;
               cnt_d    = CNT_W'(RD_LAT - 1);
               state_d  = (RD_LAT == 1) ? RD_RESP : RD_WAIT;
            end else if (awvalid && wvalid) begin
               latch_wr = 1'b1;
               cnt_d    = CNT_W'(WR_LAT - 1);
               state_d  = (WR_LAT == 1) ? WR_RESP : WR_WAIT;
            end
         end
         // Leave WAIT on the edge where the count reaches zero, so the
         // response shows up exactly *_LAT edges after acceptance.
         RD_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) state_d = RD_RESP;
         end
         WR_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) state_d = WR_RESP;
         end
         RD_RESP: state_d = IDLE;
         WR_RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The array is read on the edge entering RD_RESP so rdata changes only
   // together with rvalid. No store can run during a load, so this equals the
   // word present at acceptance. From IDLE (RD_LAT=1) the index has not been
   // latched yet and comes straight from the decode.
   logic             rd_fire, wr_commit;
   logic [IDX_W-1:0] sram_idx;
   logic             sram_zero;

   always_comb begin
      rd_fire   = (state_d == RD_RESP);
      wr_commit = (state_q == WR_RESP) && !oor_q;
      if (state_q == IDLE) begin
         sram_idx  = ar_idx;
         sram_zero = ar_oor;
      end else begin
         sram_idx  = idx_q;
         sram_zero = oor_q;
      end
   end

   ysyx_sram_1rw #(
      .DATA_W (DATA_W),
      .DEPTH  (MEM_WORDS),
      .IDX_W  (IDX_W)
   ) u_sram (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (rd_fire || wr_commit),
      .we      (wr_commit),
      .be      (be_q),
      .idx     (sram_idx),
      .wdata   (wdata_q),
      .rd_zero (sram_zero),
      .rdata   (rdata)
   );

   assign rvalid    = (state_q == RD_RESP);
   assign wready    = (state_q == WR_RESP);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ysyx_lsu_sram.sv
// ---------------------------------------------------------------------------
// tb_ysyx_lsu_sram
//   Self-checking bench for ysyx_lsu_sram (RD_LAT=2, WR_LAT=3). Expected
//   values come from a word-indexed reference memory updated byte by byte.
// ---------------------------------------------------------------------------
module tb_ysyx_lsu_sram;
   import ysyx_lsu_sram_pkg::*;

   localparam logic [31:0] TB_BASE  = 32'h8000_0000;
   localparam int          TB_WORDS = 1024;
   localparam int          RD_LAT   = 2;
   localparam int          WR_LAT   = 3;

   // ---------------- clock / reset / DUT ----------------
   logic        clk;
   logic        rst_n;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic        arvalid, awvalid, wvalid, rvalid, wready;
   logic [7:0]  rstrb, wstrb;
   lsu_state_e  dbg_state;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   ysyx_lsu_sram #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .MEM_WORDS (TB_WORDS),
      .BASE      (TB_BASE),
      .RD_LAT    (RD_LAT),
      .WR_LAT    (WR_LAT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .araddr    (araddr),
      .arvalid   (arvalid),
      .rstrb     (rstrb),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .awaddr    (awaddr),
      .awvalid   (awvalid),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wvalid    (wvalid),
      .wready    (wready),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [int unsigned];

   function automatic bit in_range(input logic [31:0] a);
      return (a >= TB_BASE) && (a < TB_BASE + 32'(4 * TB_WORDS));
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      int unsigned w;
      if (!in_range(a)) return 32'h0;
      w = (a - TB_BASE) / 4;
      return ref_mem.exists(w) ? ref_mem[w] : 32'hxxxx_xxxx;
   endfunction

   // Data byte k lands in byte (a%4 + k) of the word; bytes past 3 are lost.
   function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                       input logic [7:0] s);
      int unsigned w;
      int          p;
      logic [31:0] word;
      if (!in_range(a)) return;
      w    = (a - TB_BASE) / 4;
      word = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
      for (int k = 0; k < 4; k++) begin
         p = int'(a % 4) + k;
         if (s[k] && p < 4) word[8*p +: 8] = d[8*k +: 8];
      end
      ref_mem[w] = word;
   endfunction

   // ---------------- driver tasks (enter and leave on a negedge, FSM idle) ----
   task automatic do_read(input logic [31:0] a, output logic [31:0] d);
      int n;
      bit seen;
      araddr  = a;
      arvalid = 1'b1;
      n       = 0;
      seen    = 1'b0;
      d       = 32'hxxxx_xxxx;
      while (!seen && n < 20) begin
         @(posedge clk);
         n++;
         #1 araddr = $urandom;   // must be ignored once accepted
         @(negedge clk);
         if (rvalid) begin
            seen    = 1'b1;
            d       = rdata;
            arvalid = 1'b0;
         end
      end
      arvalid = 1'b0;
      check("rd_lat", n, RD_LAT);
      @(posedge clk);
      @(negedge clk);
      check("rvalid_pulse", {31'b0, rvalid}, 32'h0);
      check("rdata_hold", rdata, d);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
      int n;
      bit seen;
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      n       = 0;
      seen    = 1'b0;
      while (!seen && n < 20) begin
         @(posedge clk);
         n++;
         #1;
         awaddr = $urandom;
         wdata  = $urandom;
         wstrb  = 8'($urandom);
         @(negedge clk);
         if (wready) begin
            seen    = 1'b1;
            awvalid = 1'b0;
            wvalid  = 1'b0;
         end
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      model_write(a, d, s);
      check("wr_lat", n, WR_LAT);
      @(posedge clk);
      @(negedge clk);
      check("wready_pulse", {31'b0, wready}, 32'h0);
   endtask

   // ---------------- directed + random sequence ----------------
   logic [31:0] rd, a;
   logic [7:0]  strb_tab [3];
   int          rlat, wlat, cyc;
   bit          saw_wready;

   initial begin
      strb_tab = '{8'h01, 8'h03, 8'h0f};
      rst_n   = 1'b0;
      arvalid = 1'b0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      araddr  = '0;
      awaddr  = '0;
      wdata   = '0;
      wstrb   = '0;
      rstrb   = 8'h0f;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rvalid", {31'b0, rvalid}, 32'h0);
      check("rst_wready", {31'b0, wready}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      rst_n = 1'b1;
      @(negedge clk);

      // Full word store then load
      do_write(32'h8000_0010, 32'hdead_beef, 8'h0f);
      do_read(32'h8000_0010, rd);
      check("deadbeef", rd, 32'hdead_beef);

      // Byte and half stores into an existing word, then a lane that falls off
      do_write(32'h8000_0020, 32'h1122_3344, 8'h0f);
      do_write(32'h8000_0023, 32'h0000_00aa, 8'h01);
      do_read(32'h8000_0020, rd);
      check("byte_store", rd, 32'haa22_3344);
      do_write(32'h8000_0022, 32'h0000_5566, 8'h03);
      do_read(32'h8000_0020, rd);
      check("half_store", rd, 32'h5566_3344);
      do_write(32'h8000_0023, 32'h0000_ccdd, 8'h03);
      do_read(32'h8000_0020, rd);
      check("lane_drop", rd, model_read(32'h8000_0020));

      // Simultaneous load and store to the same word: load first with old data
      do_write(32'h8000_0030, 32'h0102_0304, 8'h0f);
      araddr  = 32'h8000_0030;
      arvalid = 1'b1;
      awaddr  = 32'h8000_0030;
      wdata   = 32'hcafe_f00d;
      wstrb   = 8'h0f;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      rlat = -1;
      wlat = -1;
      cyc  = 0;
      rd   = 32'hxxxx_xxxx;
      while (wlat < 0 && cyc < 40) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (rvalid) begin
            rlat    = cyc;
            rd      = rdata;
            arvalid = 1'b0;
         end
         if (wready) begin
            wlat    = cyc;
            awvalid = 1'b0;
            wvalid  = 1'b0;
         end
      end
      arvalid = 1'b0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      check("both_rlat", rlat, RD_LAT);
      check("both_rdata_old", rd, 32'h0102_0304);
      check("both_wlat", wlat, RD_LAT + 1 + WR_LAT);
      model_write(32'h8000_0030, 32'hcafe_f00d, 8'h0f);
      @(posedge clk);
      @(negedge clk);
      do_read(32'h8000_0030, rd);
      check("both_after", rd, 32'hcafe_f00d);

      // Out-of-range accesses and the edges of the window
      do_write(TB_BASE, 32'h600d_c0de, 8'h0f);
      do_write(TB_BASE + 32'(4 * TB_WORDS - 4), 32'hfeed_face, 8'h0f);
      do_read(32'h1000_0000, rd);
      check("oor_read", rd, 32'h0);
      do_write(32'h1000_0000, 32'hffff_ffff, 8'h0f);
      do_write(TB_BASE + 32'(4 * TB_WORDS), 32'hffff_ffff, 8'h0f);
      do_read(TB_BASE + 32'(4 * TB_WORDS), rd);
      check("oor_read_top", rd, 32'h0);
      do_read(TB_BASE, rd);
      check("word0_kept", rd, 32'h600d_c0de);
      do_read(TB_BASE + 32'(4 * TB_WORDS - 4), rd);
      check("last_word", rd, 32'hfeed_face);
      do_read(32'h8000_0010, rd);
      check("oor_no_change", rd, model_read(32'h8000_0010));

      // Reset during WR_WAIT aborts the store
      do_write(32'h8000_0040, 32'h0bad_f00d, 8'h0f);
      awaddr  = 32'h8000_0040;
      wdata   = 32'h1234_5678;
      wstrb   = 8'h0f;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_state_wait", 32'(dbg_state), 32'(WR_WAIT));
      rst_n   = 1'b0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
      check("mid_rst_rdata", rdata, 32'h0);
      saw_wready = 1'b0;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         if (wready) saw_wready = 1'b1;
      end
      check("mid_rst_no_wready", {31'b0, saw_wready}, 32'h0);
      do_read(32'h8000_0040, rd);
      check("mid_rst_word", rd, 32'h0bad_f00d);

      // arvalid held past the response: no second load
      araddr  = 32'h8000_0010;
      arvalid = 1'b1;
      cyc = 0;
      while (!rvalid && cyc < 20) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
      end
      check("hold_rlat", cyc, RD_LAT);
      check("hold_rdata", rdata, model_read(32'h8000_0010));
      @(posedge clk);
      @(negedge clk);
      check("hold_state1", 32'(dbg_state), 32'(IDLE));
      check("hold_rvalid1", {31'b0, rvalid}, 32'h0);
      arvalid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("hold_state2", 32'(dbg_state), 32'(IDLE));
      check("hold_rvalid2", {31'b0, rvalid}, 32'h0);

      // Randomized traffic over a small pool of words
      for (int i = 0; i < 8; i++) begin
         do_write(32'h8000_0100 + 32'(4 * i), $urandom, 8'h0f);
      end
      for (int it = 0; it < 40; it++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 5) begin
            a = 32'h8000_0100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            do_write(a, $urandom, strb_tab[$urandom_range(0, 2)]);
         end else if (r < 9) begin
            a = 32'h8000_0100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            do_read(a, rd);
            check("rand_read", rd, model_read(a));
         end else begin
            a = 32'($urandom_range(0, 32'h7fff_ffff));
            do_read(a, rd);
            check("rand_oor_read", rd, model_read(a));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish before 2ms");
      $fatal(1, "watchdog");
   end

endmodule
